coloring_checker: RTL and testbench

//  Read-side initiator for the graph memory: after the colouring engine finishes, walks the

---
 rtl/coloring_pkg.sv | 29 ++
 rtl/coloring_checker.sv | 225 ++++++++++++++++++++++
 tb/tb_coloring_checker.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/coloring_pkg.sv
// Shared constants and types for the graph-colouring checker: memory map of the
// adjacency/colour tables, graph size, FSM states and error codes.
package coloring_pkg;

  localparam logic [7:0] NODES      = 8'd33;
  localparam logic [7:0] EDGE_BASE  = 8'd0;
  localparam logic [7:0] OFS_BASE   = 8'd148;
  localparam logic [7:0] COLOR_BASE = 8'd182;
  localparam logic [7:0] SEG_BASE   = 8'd215;
  localparam logic [7:0] MAX_COLOR  = 8'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_RD_CV,
    S_RD_NBR,
    S_RD_CN,
    S_FIN
  } chk_state_t;

  typedef enum logic [1:0] {
    ERR_OK     = 2'd0,
    ERR_ADJ    = 2'd1,
    ERR_COLOR  = 2'd2,
    ERR_STRUCT = 2'd3
  } err_code_t;

endpackage

// File: rtl/coloring_checker.sv
// Read-only walker over the CSR adjacency and colour tables; reports whether the colouring is legal.
// COLOR_CHECK_COUNT_EN: scan the whole graph and count every error event in err_count.
module coloring_checker
  import coloring_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_in,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] err_code,
  output logic [7:0] err_node,
  output logic [7:0] err_nbr
`ifdef COLOR_CHECK_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  chk_state_t r_state;
  chk_state_t w_state_next;
  logic [7:0] r_addr, w_addr_next;
  logic [7:0] r_node, w_node_next;
  logic [7:0] r_ptr, w_ptr_next;
  logic [7:0] r_hi, w_hi_next;
  logic [7:0] r_cv, w_cv_next;
  logic [7:0] r_nbr, w_nbr_next;
  logic       r_pass;
  err_code_t  r_err_code;
  logic [7:0] r_err_node;
  logic [7:0] r_err_nbr;
  logic       r_err_seen;
  logic       w_evt;
  err_code_t  w_evt_code;
  logic [7:0] w_evt_nbr;
  logic       w_step;
  logic       w_adv;
  logic       w_clear;
  logic       w_enter_fin;

  assign w_clear     = start && (r_state == S_IDLE || r_state == S_FIN);
  assign w_enter_fin = (w_state_next == S_FIN) && (r_state != S_FIN);

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_node_next  = r_node;
    w_ptr_next   = r_ptr;
    w_hi_next    = r_hi;
    w_cv_next    = r_cv;
    w_nbr_next   = r_nbr;
    w_evt        = 1'b0;
    w_evt_code   = ERR_OK;
    w_evt_nbr    = 8'd0;
    w_step       = 1'b0;
    w_adv        = 1'b0;

    case (r_state)
      S_IDLE, S_FIN: begin
        if (start) begin
          w_state_next = S_RD_LO;
          w_addr_next  = OFS_BASE;
          w_node_next  = 8'd0;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RD_LO: begin
        w_ptr_next   = mem_rdata;
        w_state_next = S_RD_HI;
        w_addr_next  = OFS_BASE + r_node + 8'd1;
      end
      S_RD_HI: begin
        w_hi_next    = mem_rdata;
        w_state_next = S_RD_CV;
        w_addr_next  = COLOR_BASE + r_node;
        if (mem_rdata < r_ptr) begin
          w_evt      = 1'b1;
          w_evt_code = ERR_STRUCT;
        end
      end
      S_RD_CV: begin
        w_cv_next = mem_rdata;
        if (mem_rdata == 8'd0 || mem_rdata > MAX_COLOR) begin
          w_evt      = 1'b1;
          w_evt_code = ERR_COLOR;
        end
        // hi <= lo covers both an empty list and a malformed (reversed) one
        if (r_hi <= r_ptr) begin
          w_adv = 1'b1;
        end else begin
          w_state_next = S_RD_NBR;
          w_addr_next  = EDGE_BASE + r_ptr;
        end
      end
      S_RD_NBR: begin
        w_nbr_next = mem_rdata;
        if (mem_rdata >= NODES) begin
          w_evt      = 1'b1;
          w_evt_code = ERR_STRUCT;
          w_evt_nbr  = mem_rdata;
          w_step     = 1'b1;
        end else begin
          w_state_next = S_RD_CN;
          w_addr_next  = COLOR_BASE + mem_rdata;
        end
      end
      S_RD_CN: begin
        if (mem_rdata == r_cv) begin
          w_evt      = 1'b1;
          w_evt_code = ERR_ADJ;
          w_evt_nbr  = r_nbr;
        end
        w_step = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_step) begin
      w_ptr_next = r_ptr + 8'd1;
      if (r_ptr + 8'd1 >= r_hi) begin
        w_adv = 1'b1;
      end else begin
        w_state_next = S_RD_NBR;
        w_addr_next  = EDGE_BASE + r_ptr + 8'd1;
      end
    end

    // The hi offset of this node is the lo offset of the next, so no re-read of lo
    if (w_adv) begin
      if (r_node == NODES - 8'd1) begin
        w_state_next = S_FIN;
      end else begin
        w_node_next  = r_node + 8'd1;
        w_ptr_next   = r_hi;
        w_state_next = S_RD_HI;
        w_addr_next  = OFS_BASE + r_node + 8'd2;
      end
    end

`ifndef COLOR_CHECK_COUNT_EN
    if (w_evt) begin
      w_state_next = S_FIN;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= 8'd0;
      r_node  <= 8'd0;
      r_ptr   <= 8'd0;
      r_hi    <= 8'd0;
      r_cv    <= 8'd0;
      r_nbr   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_node  <= w_node_next;
      r_ptr   <= w_ptr_next;
      r_hi    <= w_hi_next;
      r_cv    <= w_cv_next;
      r_nbr   <= w_nbr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass     <= 1'b0;
      r_err_code <= ERR_OK;
      r_err_node <= 8'd0;
      r_err_nbr  <= 8'd0;
      r_err_seen <= 1'b0;
    end else if (w_clear) begin
      r_pass     <= 1'b0;
      r_err_code <= ERR_OK;
      r_err_node <= 8'd0;
      r_err_nbr  <= 8'd0;
      r_err_seen <= 1'b0;
    end else begin
      if (w_evt && !r_err_seen) begin
        r_err_code <= w_evt_code;
        r_err_node <= r_node;
        r_err_nbr  <= w_evt_nbr;
        r_err_seen <= 1'b1;
      end
      if (w_enter_fin) begin
        r_pass <= !(r_err_seen || w_evt);
      end
    end
  end

`ifdef COLOR_CHECK_COUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= 8'd0;
    end else if (w_clear) begin
      r_err_count <= 8'd0;
    end else if (w_evt && r_err_count != 8'hFF) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

  assign mem_addr = r_addr;
  assign mem_we   = 1'b0;
  assign mem_in   = 8'd0;
  assign busy     = (r_state != S_IDLE) && (r_state != S_FIN);
  assign done     = (r_state == S_FIN);
  assign pass     = r_pass;
  assign err_code = r_err_code;
  assign err_node = r_err_node;
  assign err_nbr  = r_err_nbr;

endmodule

// File: tb/tb_coloring_checker.sv
// Directed bench for coloring_checker: a 33-node, 74-edge graph held in a bench-side memory.
// Build with +define+COLOR_CHECK_COUNT_EN to exercise the full-scan error counter.
module tb_coloring_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_in;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [1:0] err_code;
  logic [7:0] err_node;
  logic [7:0] err_nbr;
`ifdef COLOR_CHECK_COUNT_EN
  logic [7:0] err_count;
`endif

  logic [7:0] mem [256];
  int         vecs;
  int         errs;
  logic       we_bad;

  coloring_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_in    (mem_in),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_code  (err_code),
    .err_node  (err_node),
    .err_nbr   (err_nbr)
`ifdef COLOR_CHECK_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we !== 1'b0 || mem_in !== 8'd0) we_bad = 1'b1;
  end

  // Edges join nodes 1 or 2 apart, plus (i, i+5) for i <= 10; colour (v%4)+1 is then proper.
  function automatic bit adj(int u, int v);
    int d;
    int lo;
    d  = (u > v) ? u - v : v - u;
    lo = (u < v) ? u : v;
    return (d == 1) || (d == 2) || (d == 5 && lo <= 10);
  endfunction

  task automatic load_graph(input bit zero_colors);
    int p;
    p = 0;
    for (int v = 0; v < 33; v++) begin
      mem[148 + v] = 8'(p);
      for (int u = 0; u < 33; u++) begin
        if (adj(u, v)) begin
          mem[p] = 8'(u);
          p++;
        end
      end
      mem[182 + v] = zero_colors ? 8'd0 : 8'((v % 4) + 1);
    end
    mem[148 + 33] = 8'(p);
  endtask

  task automatic start_and_wait(input int poke_at, output int cyc, output logic p1, output logic b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    p1  = pass;
    b1  = busy;
    while (done !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == poke_at);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %0b want 0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %0b want 0", done); end
    vecs++; if (pass !== 1'b0) begin errs++; $display("FAIL reset_pass got %0b want 0", pass); end
    vecs++; if (mem_addr !== 8'd0) begin errs++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
    vecs++; if ({err_code, err_node, err_nbr} !== 18'd0) begin errs++; $display("FAIL reset_err got %0d/%0d/%0d want 0/0/0", err_code, err_node, err_nbr); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: busy=%0b done=%0b pass=%0b addr=%0d", busy, done, pass, mem_addr);
  endtask

  task automatic test_illegal_color();
    int cyc; logic p1, b1;
    load_graph(1'b1);
    start_and_wait(0, cyc, p1, b1);
`ifdef COLOR_CHECK_COUNT_EN
    vecs++; if (cyc !== 364) begin errs++; $display("FAIL zero_cycles got %0d want 364", cyc); end
    vecs++; if (err_count !== 8'd181) begin errs++; $display("FAIL zero_count got %0d want 181", err_count); end
`else
    vecs++; if (cyc !== 4) begin errs++; $display("FAIL zero_cycles got %0d want 4", cyc); end
`endif
    vecs++; if (pass !== 1'b0) begin errs++; $display("FAIL zero_pass got %0b want 0", pass); end
    vecs++; if (err_code !== 2'd2 || err_node !== 8'd0 || err_nbr !== 8'd0) begin errs++; $display("FAIL zero_err got %0d/%0d/%0d want 2/0/0", err_code, err_node, err_nbr); end
    $display("zero colours: cycles=%0d pass=%0b code=%0d node=%0d nbr=%0d", cyc, pass, err_code, err_node, err_nbr);
    @(posedge clk); #1;
  endtask

  task automatic test_valid();
    int cyc; logic p1, b1;
    load_graph(1'b0);
    start_and_wait(0, cyc, p1, b1);
    vecs++; if (cyc !== 364) begin errs++; $display("FAIL valid_cycles got %0d want 364", cyc); end
    vecs++; if (b1 !== 1'b1) begin errs++; $display("FAIL valid_busy1 got %0b want 1", b1); end
    vecs++; if (pass !== 1'b1 || err_code !== 2'd0) begin errs++; $display("FAIL valid_result got pass=%0b code=%0d want 1/0", pass, err_code); end
`ifdef COLOR_CHECK_COUNT_EN
    vecs++; if (err_count !== 8'd0) begin errs++; $display("FAIL valid_count got %0d want 0", err_count); end
`endif
    @(posedge clk); #1;
    vecs++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b1) begin errs++; $display("FAIL valid_after got busy=%0b done=%0b pass=%0b want 0/0/1", busy, done, pass); end
    $display("valid: cycles=%0d pass=%0b code=%0d", cyc, pass, err_code);
  endtask

  task automatic test_adjacent();
    int cyc; logic p1, b1;
    load_graph(1'b0);
    mem[182 + 5] = 8'd1;
    start_and_wait(0, cyc, p1, b1);
`ifdef COLOR_CHECK_COUNT_EN
    vecs++; if (cyc !== 364) begin errs++; $display("FAIL adj_cycles got %0d want 364", cyc); end
    vecs++; if (err_count !== 8'd4) begin errs++; $display("FAIL adj_count got %0d want 4", err_count); end
`else
    vecs++; if (cyc !== 10) begin errs++; $display("FAIL adj_cycles got %0d want 10", cyc); end
`endif
    vecs++; if (pass !== 1'b0 || err_code !== 2'd1) begin errs++; $display("FAIL adj_code got pass=%0b code=%0d want 0/1", pass, err_code); end
    vecs++; if (err_node !== 8'd0 || err_nbr !== 8'd5) begin errs++; $display("FAIL adj_where got %0d/%0d want 0/5", err_node, err_nbr); end
    $display("adjacent: cycles=%0d code=%0d node=%0d nbr=%0d", cyc, err_code, err_node, err_nbr);
    @(posedge clk); #1;
  endtask

  task automatic test_bad_edge();
    int cyc; logic p1, b1;
    load_graph(1'b0);
    mem[7] = 8'd40;
    start_and_wait(0, cyc, p1, b1);
`ifdef COLOR_CHECK_COUNT_EN
    vecs++; if (cyc !== 363) begin errs++; $display("FAIL edge_cycles got %0d want 363", cyc); end
    vecs++; if (err_count !== 8'd1) begin errs++; $display("FAIL edge_count got %0d want 1", err_count); end
`else
    vecs++; if (cyc !== 23) begin errs++; $display("FAIL edge_cycles got %0d want 23", cyc); end
`endif
    vecs++; if (pass !== 1'b0 || err_code !== 2'd3) begin errs++; $display("FAIL edge_code got pass=%0b code=%0d want 0/3", pass, err_code); end
    vecs++; if (err_node !== 8'd2 || err_nbr !== 8'd40) begin errs++; $display("FAIL edge_where got %0d/%0d want 2/40", err_node, err_nbr); end
    $display("bad edge: cycles=%0d code=%0d node=%0d nbr=%0d", cyc, err_code, err_node, err_nbr);
    load_graph(1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    int cyc; logic p1, b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // cycle 5 is the colour read of node 0's first neighbour (node 1)
    vecs++; if (busy !== 1'b1 || mem_addr !== 8'd183) begin errs++; $display("FAIL midrun_pre got busy=%0b addr=%0d want 1/183", busy, mem_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++; if (busy !== 1'b0 || done !== 1'b0 || mem_addr !== 8'd0) begin errs++; $display("FAIL midrun_rst got busy=%0b done=%0b addr=%0d want 0/0/0", busy, done, mem_addr); end
    vecs++; if (pass !== 1'b0 || err_code !== 2'd0 || err_node !== 8'd0 || err_nbr !== 8'd0) begin errs++; $display("FAIL midrun_err got pass=%0b code=%0d node=%0d nbr=%0d want 0/0/0/0", pass, err_code, err_node, err_nbr); end
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_and_wait(0, cyc, p1, b1);
    vecs++; if (cyc !== 364 || pass !== 1'b1 || err_code !== 2'd0) begin errs++; $display("FAIL midrun_rerun got cycles=%0d pass=%0b code=%0d want 364/1/0", cyc, pass, err_code); end
    $display("reset mid-run: rerun cycles=%0d pass=%0b", cyc, pass);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc; logic p1, b1;
    start_and_wait(100, cyc, p1, b1);
    vecs++; if (cyc !== 364 || pass !== 1'b1) begin errs++; $display("FAIL ignore_start got cycles=%0d pass=%0b want 364/1", cyc, pass); end
    $display("start while busy: cycles=%0d pass=%0b", cyc, pass);
    start_and_wait(0, cyc, p1, b1);
    vecs++; if (b1 !== 1'b1 || p1 !== 1'b0) begin errs++; $display("FAIL b2b_start got busy=%0b pass=%0b want 1/0", b1, p1); end
    vecs++; if (cyc !== 364 || pass !== 1'b1) begin errs++; $display("FAIL b2b_run got cycles=%0d pass=%0b want 364/1", cyc, pass); end
    $display("back-to-back: cycles=%0d pass=%0b", cyc, pass);
    @(posedge clk); #1;
    vecs++; if (we_bad !== 1'b0) begin errs++; $display("FAIL mem_we got activity=%0b want 0", we_bad); end
  endtask

  initial begin
    vecs   = 0;
    errs   = 0;
    we_bad = 1'b0;
    start  = 1'b0;
    rst_n  = 1'b0;
    load_graph(1'b1);
    test_reset();
    test_illegal_color();
    test_valid();
    test_adjacent();
    test_bad_edge();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
